// File: rtl/cc_pkg.sv
// Shared definitions for the integral-image window generator: framing flag
// layout and the integral value width helper.
package cc_pkg;

    // Bit positions of the end-of-row / end-of-window flags in an eot vector.
    localparam int EOT_ROW = 0;
    localparam int EOT_WIN = 1;

    // Framing flags of one beat; the packed layout matches EOT_ROW / EOT_WIN.
    typedef struct packed {
        logic win;
        logic row;
    } eot_t;

    // Width that holds the sum of every pixel of a fw x fh window.
    function automatic int ii_width(input int w_data, input int fw, input int fh);
        return w_data + $clog2(fw * fh);
    endfunction

endpackage

// File: rtl/ii_line_buf.sv
// One row of previously computed integral values, indexed by column.
// Read is combinational and returns the old value in the cycle it is
// overwritten, so a read-modify-write of the same column needs no bypass.
module ii_line_buf #(
    parameter int W_II  = 18,
    parameter int DEPTH = 24,
    localparam int W_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [W_IDX-1:0] idx,
    input  logic [W_II-1:0]  wdata,
    output logic [W_II-1:0]  rdata
);

    logic [W_II-1:0] mem [DEPTH];

    assign rdata = mem[idx];

    // Store the integral value of the current column for use by the next row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/ii_window_gen.sv
// Integral image generator for one raster-ordered feature window.
// Each accepted pixel produces ii(r,c) one cycle later through a single
// registered output stage; framing flags pass through and are checked
// against the internal row/column counters, which alone drive the arithmetic.
module ii_window_gen
    import cc_pkg::*;
#(
    parameter int W_DATA         = 8,
    parameter int FEATURE_WIDTH  = 24,
    parameter int FEATURE_HEIGHT = 24,
    localparam int W_II = ii_width(W_DATA, FEATURE_WIDTH, FEATURE_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [W_DATA-1:0] din_data,
    input  logic [1:0]        din_eot,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_II-1:0]   dout_data,
    output logic [1:0]        dout_eot,
    output logic              dout_err
);

    localparam int W_C = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
    localparam int W_R = (FEATURE_HEIGHT > 1) ? $clog2(FEATURE_HEIGHT) : 1;
    localparam logic [W_C-1:0]  C_LAST  = W_C'(FEATURE_WIDTH - 1);
    localparam logic [W_R-1:0]  R_LAST  = W_R'(FEATURE_HEIGHT - 1);
    localparam logic [W_II-1:0] ZERO_II = '0;

    logic [W_C-1:0]  c;
    logic [W_R-1:0]  r;
    logic [W_II-1:0] rs;
    logic [W_II-1:0] rs_base;
    logic [W_II-1:0] rs_n;
    logic [W_II-1:0] above;
    logic [W_II-1:0] ii;
    logic [W_II-1:0] lb_rd;
    logic            accept;
    logic            c_last;
    logic            r_last;
    eot_t            eot_in;
    eot_t            eot_exp;

    // The output register frees up whenever it is empty or being drained.
    assign din_ready = !dout_valid | dout_ready;
    assign accept    = din_valid & din_ready;
    assign c_last    = (c == C_LAST);
    assign r_last    = (r == R_LAST);

    // Row sum and integral value; row 0 and column 0 mask stale state.
    always_comb begin
        eot_in      = eot_t'(din_eot);
        eot_exp.row = c_last;
        eot_exp.win = c_last & r_last;
        rs_base     = (c == '0) ? ZERO_II : rs;
        above       = (r == '0) ? ZERO_II : lb_rd;
        rs_n        = rs_base + W_II'(din_data);
        ii          = rs_n + above;
    end

    // Raster position and running row sum; an accepted end-of-window flag
    // resynchronises the position to (0,0) regardless of where we think we are.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c  <= '0;
            r  <= '0;
            rs <= '0;
        end else if (accept) begin
            rs <= rs_n;
            if (eot_in.win) begin
                c <= '0;
                r <= '0;
            end else if (c_last) begin
                c <= '0;
                r <= r_last ? '0 : r + W_R'(1);
            end else begin
                c <= c + W_C'(1);
            end
        end
    end

    // Output stage: load on accept (even while draining), otherwise empty on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_eot   <= '0;
            dout_err   <= 1'b0;
        end else if (accept) begin
            dout_valid <= 1'b1;
            dout_data  <= ii;
            dout_eot   <= din_eot;
            dout_err   <= (eot_in != eot_exp);
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    ii_line_buf #(
        .W_II  (W_II),
        .DEPTH (FEATURE_WIDTH)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .idx   (c),
        .wdata (ii),
        .rdata (lb_rd)
    );

endmodule
